// File: rtl/pcc_feature_binarizer_if.sv
// Feature-in / sample-out handshake bundle for the pcc feature binarizer.
// slave = binarizer side, master = feeder/consumer side.
interface pcc_feature_binarizer_if #(
  parameter int NPOS   = 2,
  parameter int NNEG   = 3,
  parameter int FEAT_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [FEAT_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [NPOS-1:0]   out_pos;
  logic [NNEG-1:0]   out_neg;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_pos, out_neg
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_pos, out_neg
  );
endinterface

// File: rtl/pcc_feature_binarizer.sv
// Thresholds a stream of features into pos/neg bit vectors, one sample per N features.
// Optional framing check on in_last is enabled by defining PCC_FRAME_CHECK_EN.
module pcc_feature_binarizer #(
  parameter int NPOS   = 2,
  parameter int NNEG   = 3,
  parameter int FEAT_W = 8,
  localparam int N     = NPOS + NNEG,
  localparam int AW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [FEAT_W-1:0] cfg_data,
  pcc_feature_binarizer_if.slave bus,
  output logic              err
);
  localparam logic [AW-1:0] LP_LAST = AW'(N - 1);

  logic [FEAT_W-1:0] r_thr [N];
  logic [AW-1:0]     r_idx;
  logic [N-1:0]      r_col;
  logic [N-1:0]      r_out;
  logic              r_vld;
  logic [N-1:0]      w_col;
  logic              w_acc;
  logic              w_last_idx;
  logic              w_bit;
  logic              w_early;

  assign w_last_idx   = (r_idx == LP_LAST);
  // Only the sample-completing feature can be blocked by a full output buffer.
  assign bus.in_ready = !(w_last_idx && r_vld && !bus.out_ready);
  assign w_acc        = bus.in_valid && bus.in_ready;
  assign w_bit        = (bus.in_data >= r_thr[r_idx]);

  always_comb begin
    w_col        = r_col;
    w_col[r_idx] = w_bit;
  end

  // Out-of-range addresses match no entry and are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) r_thr[k] <= '0;
    end else if (cfg_we) begin
      for (int k = 0; k < N; k++)
        if (cfg_addr == AW'(k)) r_thr[k] <= cfg_data;
    end
  end

`ifdef PCC_FRAME_CHECK_EN
  logic w_miss;
  logic r_err;

  assign w_early = w_acc && bus.in_last && !w_last_idx;
  assign w_miss  = w_acc && !bus.in_last && w_last_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_early || w_miss;
  end

  assign err = r_err;
`else
  logic w_unused_last;

  assign w_unused_last = bus.in_last;
  assign w_early       = 1'b0;
  assign err           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_col <= '0;
      r_out <= '0;
      r_vld <= 1'b0;
    end else if (w_acc && w_last_idx) begin
      // Completion overwrites the buffer; in_ready guarantees it was free or draining.
      r_out <= w_col;
      r_vld <= 1'b1;
      r_col <= '0;
      r_idx <= '0;
    end else begin
      if (bus.out_ready) r_vld <= 1'b0;
      if (w_early) begin
        r_col <= '0;
        r_idx <= '0;
      end else if (w_acc) begin
        r_col <= w_col;
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.out_valid = r_vld;
  assign bus.out_pos   = r_out[NPOS-1:0];
  assign bus.out_neg   = r_out[N-1:NPOS];
endmodule
